// File: rtl/dual_port_ram_sync.sv
// Single-clock true dual-port RAM: registered write-first reads, port A wins write collisions.
// Optional post-reset clear engine compiled in with `define DPRAM_CLEAR_EN.
module dual_port_ram_sync #(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            ADDR_WIDTH  = 15,
  parameter int unsigned            DEPTH       = 32768,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic                  rd_csA,
  input  logic                  wr_csA,
  input  logic [DATA_WIDTH-1:0] wr_dataA,
  output logic [DATA_WIDTH-1:0] rd_dataA,
  output logic                  rd_validA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic                  rd_csB,
  input  logic                  wr_csB,
  input  logic [DATA_WIDTH-1:0] wr_dataB,
  output logic [DATA_WIDTH-1:0] rd_dataB,
  output logic                  rd_validB,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  acc;
  logic                  in_a, in_b;
  logic                  wr_a_ok, wr_b_ok;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

`ifdef DPRAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_WIDTH'(1);
      if (cnt == LAST) state <= READY;
    end
  end

  assign busy = (state == CLEAR);
  assign acc  = !reset && (state == READY);
`else
  assign busy = 1'b0;
  assign acc  = !reset;
`endif

  assign in_a    = {1'b0, addrA} < DEPTH_W;
  assign in_b    = {1'b0, addrB} < DEPTH_W;
  assign wr_a_ok = acc && wr_csA && in_a;
  assign wr_b_ok = acc && wr_csB && in_b;

  // Port A is written last so it overrides port B on a same-address collision.
  always_ff @(posedge clock) begin
`ifdef DPRAM_CLEAR_EN
    if (!reset && state == CLEAR) mem[cnt] <= CLEAR_VALUE;
`endif
    if (wr_b_ok) mem[addrB] <= wr_dataB;
    if (wr_a_ok) mem[addrA] <= wr_dataA;
  end

  // Write-first bypass: a read sees the word the memory will hold after this edge.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (in_a) begin
      if (wr_a_ok)                        fwd_a = wr_dataA;
      else if (wr_b_ok && addrB == addrA) fwd_a = wr_dataB;
      else                                fwd_a = mem[addrA];
    end
    if (in_b) begin
      if (wr_a_ok && addrA == addrB)      fwd_b = wr_dataA;
      else if (wr_b_ok)                   fwd_b = wr_dataB;
      else                                fwd_b = mem[addrB];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_dataA  <= '0;
      rd_dataB  <= '0;
      rd_validA <= 1'b0;
      rd_validB <= 1'b0;
    end else begin
      rd_validA <= acc && rd_csA;
      rd_validB <= acc && rd_csB;
      if (acc && rd_csA) rd_dataA <= fwd_a;
      if (acc && rd_csB) rd_dataB <= fwd_b;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Randomized bench for dual_port_ram_sync (DEPTH=12, ADDR_WIDTH=4) against an array model.
// Builds with or without DPRAM_CLEAR_EN.
module tb_dual_port_ram_sync;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam logic [DW-1:0] CV = 8'h3C;
`ifdef DPRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr_a, addr_b;
  logic          rd_a, rd_b, wr_a, wr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          valid_a, valid_b, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dual_port_ram_sync #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .CLEAR_VALUE(CV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .addrA    (addr_a),
    .rd_csA   (rd_a),
    .wr_csA   (wr_a),
    .wr_dataA (wdata_a),
    .rd_dataA (rdata_a),
    .rd_validA(valid_a),
    .addrB    (addr_b),
    .rd_csB   (rd_b),
    .wr_csB   (wr_b),
    .wr_dataB (wdata_b),
    .rd_dataB (rdata_b),
    .rd_validB(valid_b),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the cycle's writes (B, then A so A wins), then serve reads.
  logic [DW-1:0] model [16];
  bit            known [16];
  int            clear_left = 0;
  bit            armed = 1'b0;
  bit            exp_busy, exp_va, exp_vb, exp_ka, exp_kb;
  logic [DW-1:0] exp_da, exp_db;

  always @(posedge clock) begin
    if (reset) begin
      armed      = 1'b1;
      clear_left = CLR ? DEPTH : 0;
      exp_va = 1'b0; exp_vb = 1'b0;
      exp_da = '0;   exp_db = '0;
      exp_ka = 1'b1; exp_kb = 1'b1;
    end else if (clear_left > 0) begin
      model[4'(DEPTH - clear_left)] = CV;
      known[4'(DEPTH - clear_left)] = 1'b1;
      clear_left--;
      exp_va = 1'b0; exp_vb = 1'b0;
    end else begin
      if (wr_b && int'(addr_b) < DEPTH) begin model[addr_b] = wdata_b; known[addr_b] = 1'b1; end
      if (wr_a && int'(addr_a) < DEPTH) begin model[addr_a] = wdata_a; known[addr_a] = 1'b1; end
      exp_va = rd_a;
      exp_vb = rd_b;
      if (rd_a) begin
        exp_ka = (int'(addr_a) < DEPTH) ? known[addr_a] : 1'b1;
        exp_da = (int'(addr_a) < DEPTH) ? model[addr_a] : '0;
      end
      if (rd_b) begin
        exp_kb = (int'(addr_b) < DEPTH) ? known[addr_b] : 1'b1;
        exp_db = (int'(addr_b) < DEPTH) ? model[addr_b] : '0;
      end
    end
    exp_busy = (clear_left > 0);
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rd_validA", 32'(valid_a), 32'(exp_va));
      chk("rd_validB", 32'(valid_b), 32'(exp_vb));
      if (exp_ka) chk("rd_dataA", 32'(rdata_a), 32'(exp_da));
      if (exp_kb) chk("rd_dataB", 32'(rdata_b), 32'(exp_db));
    end
  end

  task automatic idle();
    rd_a = 1'b0; rd_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with busy high, bounded so a stuck busy still reaches the summary.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
      wr_a = 1'b0;
    end
  endtask

  initial begin
    int n;
    idle();
    reset = 1'b1;
    repeat (3) step();
    chk("reset_busy", 32'(busy), 32'(CLR));
    chk("reset_validA", 32'(valid_a), 32'd0);
    chk("reset_dataB", 32'(rdata_b), 32'd0);
    reset = 1'b0;

    // Write attempted in the first clear cycle must be dropped.
    wr_a = 1'b1; addr_a = 4'd0; wdata_a = 8'hFF;
    count_busy(n);
    chk("clear_cycles", 32'(n), CLR ? 32'(DEPTH) : 32'd0);
    idle();

`ifdef DPRAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      rd_a = 1'b1; addr_a = 4'(i);
      step();
      chk("clear_read_valid", 32'(valid_a), 32'd1);
      chk("clear_read_data", 32'(rdata_a), 32'(CV));
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      wr_a = 1'b1; addr_a = 4'(i); wdata_a = 8'(i * 7 + 1);
      step();
    end
`endif
    idle();
    step();

    wr_a = 1'b1; addr_a = 4'd3; wdata_a = 8'hA5;
    step();
    idle();
    rd_b = 1'b1; addr_b = 4'd3;
    step();
    chk("basic_validB", 32'(valid_b), 32'd1);
    chk("basic_dataB", 32'(rdata_b), 32'hA5);
    idle();
    step();
    chk("basic_validB_drop", 32'(valid_b), 32'd0);
    chk("basic_dataB_hold", 32'(rdata_b), 32'hA5);

    wr_a = 1'b1; addr_a = 4'd7; wdata_a = 8'h11;
    wr_b = 1'b1; addr_b = 4'd7; wdata_b = 8'h22;
    step();
    idle();
    rd_a = 1'b1; addr_a = 4'd7;
    step();
    chk("collision_dataA", 32'(rdata_a), 32'h11);
    idle();

    wr_a = 1'b1; rd_a = 1'b1; addr_a = 4'd10; wdata_a = 8'h5C;
    rd_b = 1'b1; addr_b = 4'd10;
    step();
    chk("rdw_dataB", 32'(rdata_b), 32'h5C);
    chk("rdw_validB", 32'(valid_b), 32'd1);
    chk("rdw_dataA_own", 32'(rdata_a), 32'h5C);
    idle();

    wr_a = 1'b1; addr_a = 4'd13; wdata_a = 8'h77;
    step();
    idle();
    rd_a = 1'b1; addr_a = 4'd13;
    step();
    chk("oor_validA", 32'(valid_a), 32'd1);
    chk("oor_dataA", 32'(rdata_a), 32'd0);
    addr_a = 4'd1;
    step();
    chk("oor_neighbour", 32'(rdata_a), CLR ? 32'(CV) : 32'h08);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rd_a    = 1'($urandom_range(0, 1));
      rd_b    = 1'($urandom_range(0, 1));
      wr_a    = ($urandom_range(0, 2) == 0);
      wr_b    = ($urandom_range(0, 2) == 0);
      addr_a  = 4'($urandom_range(0, 15));
      addr_b  = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom_range(0, 15));
      wdata_a = 8'($urandom);
      wdata_b = 8'($urandom);
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    idle();

    // Reset part-way through a clear restarts it from address 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("busy_mid_clear", 32'(busy), 32'(CLR));
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(n);
    chk("clear_restart_cycles", 32'(n), CLR ? 32'(DEPTH) : 32'd0);
    idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
